// File: rtl/multi_channel_ping_pong_counter_pkg.sv
// Shared definitions for the multi-channel ping-pong counter bank.
// Holds the per-channel mode codes that select how a counter behaves
// when it reaches a bound.
package multi_channel_ping_pong_counter_pkg;

    localparam logic [1:0] PPC_PINGPONG = 2'b00;  // reverse at each bound
    localparam logic [1:0] PPC_WRAP     = 2'b01;  // jump to the opposite bound
    localparam logic [1:0] PPC_ONESHOT  = 2'b10;  // single sweep, then park
    localparam logic [1:0] PPC_HOLD     = 2'b11;  // freeze value and direction

endpackage

// File: rtl/multi_channel_ping_pong_counter_channel.sv
// ppc_channel: one bounded up/down counter with its next-state logic and
// output registers.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (loads min, direction up)
//   enable     count enable; low holds value and direction
//   flip       direction-reverse request
//   mode       PPC_* mode code
//   max, min   inclusive bounds; range is valid only when max > min
//   out        registered counter value
//   direction  1 = counting up, 0 = counting down
//   bounce     registered one-cycle boundary-event pulse
module ppc_channel
    import multi_channel_ping_pong_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             flip,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    output logic [WIDTH-1:0] out,
    output logic             direction,
    output logic             bounce
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             dir_q, dir_d;
    logic             bounce_q, bounce_d;

    logic [WIDTH-1:0] fwd;       // one step in the current direction
    logic [WIDTH-1:0] back;      // one step against the current direction
    logic [WIDTH-1:0] end_val;   // the bound the counter is heading towards
    logic             at_end;
    logic             interior;

    assign fwd      = dir_q ? out_q + ONE : out_q - ONE;
    assign back     = dir_q ? out_q - ONE : out_q + ONE;
    assign end_val  = dir_q ? max : min;
    assign at_end   = (out_q == end_val);
    assign interior = (out_q > min) && (out_q < max);

    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        bounce_d = 1'b0;
        if (enable && (max > min)) begin
            if ((out_q < min) || (out_q > max)) begin
                // Bounds moved away from the current value: restart the sweep.
                out_d = min;
                dir_d = 1'b1;
            end else if (mode != PPC_HOLD) begin
                if (flip && interior) begin
                    // Reverse and step in the new direction on the same edge.
                    dir_d = ~dir_q;
                    out_d = back;
                end else begin
                    // A flip at a bound falls through here and is ignored,
                    // except for a parked one-shot where it restarts the sweep.
                    case (mode)
                        PPC_PINGPONG: begin
                            if (at_end) begin
                                dir_d    = ~dir_q;
                                out_d    = back;
                                bounce_d = 1'b1;
                            end else begin
                                out_d = fwd;
                            end
                        end
                        PPC_WRAP: begin
                            if (at_end) begin
                                out_d    = dir_q ? min : max;
                                bounce_d = 1'b1;
                            end else begin
                                out_d = fwd;
                            end
                        end
                        default: begin
                            // One-shot: pulse on arrival, then park at the bound.
                            if (!at_end) begin
                                out_d    = fwd;
                                bounce_d = (fwd == end_val);
                            end else if (flip) begin
                                dir_d = ~dir_q;
                                out_d = back;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q    <= min;
            dir_q    <= 1'b1;
            bounce_q <= 1'b0;
        end else begin
            out_q    <= out_d;
            dir_q    <= dir_d;
            bounce_q <= bounce_d;
        end
    end

    assign out       = out_q;
    assign direction = dir_q;
    assign bounce    = bounce_q;

endmodule

// File: rtl/multi_channel_ping_pong_counter.sv
// multi_channel_ping_pong_counter: bank of CHANNELS independent bounded
// up/down counters sharing one clock.
// Ports (channel c occupies slice c of every bus):
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   enable     [CHANNELS]        per-channel count enable
//   flip       [CHANNELS]        per-channel direction-reverse request
//   mode       [2*CHANNELS]      per-channel mode, ch c = mode[2c+1:2c]
//   max, min   [WIDTH*CHANNELS]  per-channel bounds, ch c = [WIDTH*c +: WIDTH]
//   out        [WIDTH*CHANNELS]  counter values, same packing
//   direction  [CHANNELS]        1 = up, 0 = down
//   bounce     [CHANNELS]        registered boundary-event pulse
module multi_channel_ping_pong_counter
    import multi_channel_ping_pong_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       flip,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [WIDTH*CHANNELS-1:0] max,
    input  logic [WIDTH*CHANNELS-1:0] min,
    output logic [WIDTH*CHANNELS-1:0] out,
    output logic [CHANNELS-1:0]       direction,
    output logic [CHANNELS-1:0]       bounce
);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        ppc_channel #(.WIDTH(WIDTH)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable[c]),
            .flip      (flip[c]),
            .mode      (mode[2*c +: 2]),
            .max       (max[WIDTH*c +: WIDTH]),
            .min       (min[WIDTH*c +: WIDTH]),
            .out       (out[WIDTH*c +: WIDTH]),
            .direction (direction[c]),
            .bounce    (bounce[c])
        );
    end

endmodule

// File: tb/tb_multi_channel_ping_pong_counter.sv
// Testbench for multi_channel_ping_pong_counter (WIDTH=4, CHANNELS=2).
// Directed scenarios followed by randomized traffic, all checked every
// cycle against a behavioural model of each channel.
module tb_multi_channel_ping_pong_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] enable;
    logic [1:0] flip;
    logic [3:0] mode;
    logic [7:0] max_v;
    logic [7:0] min_v;
    logic [7:0] out_w;
    logic [1:0] dir_w;
    logic [1:0] bounce_w;

    int n_vec = 0;
    int n_err = 0;

    int m_out [2];
    int m_dir [2];
    int m_b   [2];

    always #5 clk = ~clk;

    multi_channel_ping_pong_counter #(.WIDTH(4), .CHANNELS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .flip      (flip),
        .mode      (mode),
        .max       (max_v),
        .min       (min_v),
        .out       (out_w),
        .direction (dir_w),
        .bounce    (bounce_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Next state of channel c from the behavioural rules, in plain integers.
    function automatic void model_next(input int c, output int no, output int nd, output int nb);
        int o, d, lo, hi, md, tgt, s;
        o  = m_out[c];
        d  = m_dir[c];
        lo = int'(min_v[4*c +: 4]);
        hi = int'(max_v[4*c +: 4]);
        md = int'(mode[2*c +: 2]);
        no = o; nd = d; nb = 0;
        if (rst) begin no = lo; nd = 1; return; end
        if (!enable[c] || hi <= lo) return;
        if (o < lo || o > hi) begin no = lo; nd = 1; return; end
        if (md == 3) return;
        tgt = (d == 1) ? hi : lo;
        s   = (d == 1) ? 1 : -1;
        if (flip[c] && o > lo && o < hi) begin nd = 1 - d; no = o - s; return; end
        if (md == 0) begin
            if (o == tgt) begin nd = 1 - d; no = o - s; nb = 1; end
            else no = o + s;
        end else if (md == 1) begin
            if (o == tgt) begin no = (d == 1) ? lo : hi; nb = 1; end
            else no = o + s;
        end else begin
            if (o == tgt) begin
                if (flip[c]) begin nd = 1 - d; no = o - s; end
            end else begin
                no = o + s;
                nb = (no == tgt) ? 1 : 0;
            end
        end
    endfunction

    task automatic step();
        int no0, nd0, nb0, no1, nd1, nb1;
        model_next(0, no0, nd0, nb0);
        model_next(1, no1, nd1, nb1);
        @(posedge clk);
        #1;
        m_out[0] = no0; m_dir[0] = nd0; m_b[0] = nb0;
        m_out[1] = no1; m_dir[1] = nd1; m_b[1] = nb1;
        for (int c = 0; c < 2; c++) begin
            check($sformatf("out%0d", c), 32'(out_w[4*c +: 4]), 32'(m_out[c]));
            check($sformatf("dir%0d", c), 32'(dir_w[c]), 32'(m_dir[c]));
            check($sformatf("bounce%0d", c), 32'(bounce_w[c]), 32'(m_b[c]));
        end
    endtask

    task automatic set_ch(input int c, input logic [1:0] md, input logic [3:0] lo, input logic [3:0] hi);
        mode[2*c +: 2]  = md;
        min_v[4*c +: 4] = lo;
        max_v[4*c +: 4] = hi;
    endtask

    int exp1_out [7] = '{4, 5, 6, 5, 4, 3, 4};
    int exp1_b   [7] = '{0, 0, 0, 1, 0, 0, 1};
    int exp3_out [9] = '{3, 4, 5, 5, 5, 4, 3, 2, 2};
    int exp3_b   [9] = '{0, 0, 1, 0, 0, 0, 0, 1, 0};
    int exp6_out [6] = '{1, 2, 3, 2, 1, 0};

    initial begin
        int found;
        rst = 1'b1; enable = 2'b00; flip = 2'b00;
        mode = 4'b0; min_v = 8'b0; max_v = 8'b0;
        m_out = '{0, 0}; m_dir = '{1, 1}; m_b = '{0, 0};

        // 1: reset loads min, then ping-pong 3..6
        set_ch(0, 2'b00, 4'd3, 4'd6);
        set_ch(1, 2'b01, 4'd0, 4'd15);
        step();
        check("t1_rst_out0", 32'(out_w[3:0]), 32'd3);
        check("t1_rst_dir0", 32'(dir_w[0]), 32'd1);
        check("t1_rst_bounce", 32'(bounce_w), 32'd0);
        rst = 1'b0; enable = 2'b11;
        for (int i = 0; i < 7; i++) begin
            step();
            check("t1_seq_out0", 32'(out_w[3:0]), 32'(exp1_out[i]));
            check("t1_seq_bounce0", 32'(bounce_w[0]), 32'(exp1_b[i]));
        end

        // 2: wrap channel wraps 15->0, flip, then wraps down 0->15
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            step();
            if (out_w[7:4] == 4'd1) found = 1;
        end
        check("t2_wait_out1", 32'(found), 32'd1);
        flip = 2'b10;
        step();
        check("t2_flip_out1", 32'(out_w[7:4]), 32'd0);
        flip = 2'b00;
        step();
        check("t2_wrapdn_out1", 32'(out_w[7:4]), 32'd15);
        check("t2_wrapdn_bounce1", 32'(bounce_w[1]), 32'd1);

        // 3: one-shot sweep up, park, flip restarts it downwards
        set_ch(0, 2'b10, 4'd2, 4'd5);
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            flip[0] = (i == 5);
            step();
            check("t3_seq_out0", 32'(out_w[3:0]), 32'(exp3_out[i]));
            check("t3_seq_bounce0", 32'(bounce_w[0]), 32'(exp3_b[i]));
        end
        flip = 2'b00;

        // 4: interior flip, flip at the top bound, enable low
        set_ch(0, 2'b00, 4'd0, 4'd15);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (out_w[3:0] == 4'd7 && dir_w[0]) found = 1;
        end
        check("t4_wait7", 32'(found), 32'd1);
        flip = 2'b01; step(); flip = 2'b00;
        check("t4_flip_out0", 32'(out_w[3:0]), 32'd6);
        check("t4_flip_dir0", 32'(dir_w[0]), 32'd0);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (out_w[3:0] == 4'd15) found = 1;
        end
        check("t4_wait15", 32'(found), 32'd1);
        flip = 2'b01; step(); flip = 2'b00;
        check("t4_topflip_out0", 32'(out_w[3:0]), 32'd14);
        check("t4_topflip_dir0", 32'(dir_w[0]), 32'd0);
        enable = 2'b10;
        for (int i = 0; i < 3; i++) begin
            flip = 2'b01;
            step();
            check("t4_hold_out0", 32'(out_w[3:0]), 32'd14);
            check("t4_hold_bounce0", 32'(bounce_w[0]), 32'd0);
        end
        flip = 2'b00; enable = 2'b11;

        // 5: invalid range holds, out-of-range reload, mid-count reset
        set_ch(0, 2'b00, 4'd9, 4'd9);
        for (int i = 0; i < 2; i++) begin
            step();
            check("t5_invalid_out0", 32'(out_w[3:0]), 32'd14);
        end
        set_ch(0, 2'b00, 4'd0, 4'd15);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            step();
            if (out_w[3:0] == 4'd4) found = 1;
        end
        check("t5_wait4", 32'(found), 32'd1);
        set_ch(0, 2'b00, 4'd10, 4'd12);
        step();
        check("t5_reload_out0", 32'(out_w[3:0]), 32'd10);
        check("t5_reload_dir0", 32'(dir_w[0]), 32'd1);
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        check("t5_rst_out0", 32'(out_w[3:0]), 32'd10);

        // 6: channel isolation
        set_ch(0, 2'b11, 4'd10, 4'd12);
        set_ch(1, 2'b00, 4'd0, 4'd3);
        rst = 1'b1; step(); rst = 1'b0;
        check("t6_rst_out1", 32'(out_w[7:4]), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("t6_out1", 32'(out_w[7:4]), 32'(exp6_out[i]));
            check("t6_out0", 32'(out_w[3:0]), 32'd10);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom_range(0, 49) == 0);
            enable = {($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0)};
            flip   = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(0, 7) == 0)
                    set_ch(c, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                           4'($urandom_range(0, 15)));
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
